ifetch_unit: RTL and testbench

Instruction fetch and PC sequencing stage that sits directly upstream of the main decoder `ctrl`. It owns the program counter and fetches each instruction from instruction memory through a req/rdy handshake, then holds it stable in an instruction register while `ctrl` decodes it. It applies `ctrl`'s `NPCOp` to compute the next PC. It also provides a per-instruction `commit` strobe; the datapath ANDs `RegWrite` and `MemWrite` with `commit` so the core runs correctly with a multi-cycle or wait-stated instruction memory.

---
 rtl/ifetch_unit_pkg.sv | 21 ++
 rtl/ifetch_unit_npc_calc.sv | 31 +++
 rtl/ifetch_unit.sv | 98 +++++++++
 tb/tb_ifetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared next-PC and fetch-state encodings for ifetch_unit
package ifetch_unit_pkg;

    // Next-PC selection driven by ctrl
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // Fetch sequencer states
    localparam logic [1:0] IF_IDLE  = 2'b00;
    localparam logic [1:0] IF_FETCH = 2'b01;
    localparam logic [1:0] IF_EXEC  = 2'b10;
    localparam logic [1:0] IF_HALT  = 2'b11;

    // Branch displacement: sign-extended 16-bit word offset converted to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// rtl/ifetch_unit_npc_calc.sv - combinational next-PC arithmetic
module npc_calc (
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_data,
    input  logic [1:0]  NPCOp,
    output logic [31:0] npc,
    output logic        misalign
);
    import ifetch_unit_pkg::*;

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Select the successor PC; all sums wrap modulo 2^32
    always_comb begin
        npc = pc_plus4;
        case (NPCOp)
            NPC_PLUS4:  npc = pc_plus4;
            NPC_BRANCH: npc = pc_plus4 + branch_offset(instr_idx[15:0]);
            NPC_JUMP:   npc = {pc_plus4[31:28], instr_idx, 2'b00};
            NPC_JR:     npc = rs_data;
            default:    npc = pc_plus4;
        endcase
    end

    // Only a register target can land off a word boundary
    assign misalign = |npc[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC sequencer and instruction fetch with req/rdy memory handshake
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] rs_data,
    input  logic        hold,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        commit,
    output logic        fault
);
    import ifetch_unit_pkg::*;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] npc;
    logic        misalign;

    npc_calc u_npc_calc (
        .pc        (pc_q),
        .instr_idx (instr_q[25:0]),
        .rs_data   (rs_data),
        .NPCOp     (NPCOp),
        .npc       (npc),
        .misalign  (misalign)
    );

    // Sequencer: one IDLE cycle, fetch until rdy, execute until hold drops, halt on bad target
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_FETCH;
            end
            IF_FETCH: begin
                if (imem_rdy) begin
                    instr_d = imem_rdata;
                    state_d = IF_EXEC;
                end
            end
            IF_EXEC: begin
                if (!hold) begin
                    if (misalign) begin
                        fault_d = 1'b1;
                        state_d = IF_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = IF_FETCH;
                    end
                end
            end
            IF_HALT: begin
                state_d = IF_HALT;
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    // State registers; reset overrides any handshake or commit on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Strobes are masked during reset so an in-flight fetch or commit is dropped cleanly
    assign imem_req  = ~rst & (state_q == IF_FETCH);
    assign imem_addr = pc_q;
    assign commit    = ~rst & (state_q == IF_EXEC) & ~hold;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign fault     = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with a transaction-level model
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [1:0]  NPCOp;
    logic [31:0] rs_data;
    logic        hold;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_fault;

    ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .NPCOp      (NPCOp),
        .rs_data    (rs_data),
        .hold       (hold),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [31:0] word,
                                              input logic [1:0] op, input logic [31:0] rs);
        int off;
        case (op)
            2'd0: return cur_pc + 32'd4;
            2'd1: begin
                off = int'($signed(word[15:0]));
                return cur_pc + 32'd4 + 32'(off * 4);
            end
            2'd2: return ((cur_pc + 32'd4) & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
            default: return rs;
        endcase
    endfunction

    // Asserts rst from whatever state the DUT is in; hold=0 so an EXEC commit would be visible
    task automatic do_reset();
        rst        = 1'b1;
        hold       = 1'b0;
        imem_rdy   = 1'(($urandom));
        imem_rdata = $urandom;
        NPCOp      = 2'(($urandom));
        rs_data    = $urandom;
        #1;
        check_eq("rst_in_req", 32'(imem_req), 32'd0);
        check_eq("rst_in_commit", 32'(commit), 32'd0);
        step();
        m_pc    = 32'h0000_3000;
        m_instr = 32'd0;
        m_fault = 1'b0;
        check_eq("rst_pc", pc, m_pc);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_commit", 32'(commit), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        rst      = 1'b0;
        imem_rdy = 1'b1;
        #1;
        check_eq("idle_pc", pc, m_pc);
        check_eq("idle_instr", instr, 32'd0);
        check_eq("idle_req", 32'(imem_req), 32'd0);
        check_eq("idle_commit", 32'(commit), 32'd0);
        check_eq("idle_fault", 32'(fault), 32'd0);
        step();
    endtask

    // Memory side: w wait cycles, then rdy with the word
    task automatic do_fetch(input int w, input logic [31:0] word);
        for (int i = 0; i <= w; i++) begin
            imem_rdy   = (i == w);
            imem_rdata = (i == w) ? word : $urandom;
            hold       = 1'(($urandom));
            NPCOp      = 2'(($urandom));
            rs_data    = $urandom;
            #1;
            check_eq("fetch_req", 32'(imem_req), 32'd1);
            check_eq("fetch_addr", imem_addr, m_pc);
            check_eq("fetch_commit", 32'(commit), 32'd0);
            check_eq("fetch_instr", instr, m_instr);
            check_eq("fetch_pc", pc, m_pc);
            step();
        end
        m_instr = word;
    endtask

    // Execute: h hold cycles then one commit; afterwards a misaligned target halts the unit
    task automatic do_exec(input logic [1:0] op, input logic [31:0] rs, input int h);
        logic [31:0] nxt;
        NPCOp   = op;
        rs_data = rs;
        for (int j = 0; j <= h; j++) begin
            hold       = (j < h);
            imem_rdy   = 1'(($urandom));
            imem_rdata = $urandom;
            #1;
            check_eq("exec_req", 32'(imem_req), 32'd0);
            check_eq("exec_pc", pc, m_pc);
            check_eq("exec_pc4", pc_plus4, m_pc + 32'd4);
            check_eq("exec_instr", instr, m_instr);
            check_eq("exec_commit", 32'(commit), 32'(j == h));
            check_eq("exec_fault", 32'(fault), 32'd0);
            step();
        end
        nxt = model_npc(m_pc, m_instr, op, rs);
        if (nxt % 4 != 0) m_fault = 1'b1;
        else              m_pc    = nxt;
        if (m_fault) begin
            for (int k = 0; k < 3; k++) begin
                imem_rdy = 1'b1;
                hold     = 1'b0;
                #1;
                check_eq("halt_fault", 32'(fault), 32'd1);
                check_eq("halt_req", 32'(imem_req), 32'd0);
                check_eq("halt_commit", 32'(commit), 32'd0);
                check_eq("halt_pc", pc, m_pc);
                check_eq("halt_instr", instr, m_instr);
                step();
            end
        end
    endtask

    task automatic do_instr(input int w, input logic [31:0] word, input logic [1:0] op,
                            input logic [31:0] rs, input int h);
        do_fetch(w, word);
        do_exec(op, rs, h);
    endtask

    initial begin
        rst = 1'b1; imem_rdy = 1'b0; imem_rdata = '0; NPCOp = '0; rs_data = '0; hold = 1'b0;
        m_pc = 32'h0000_3000; m_instr = '0; m_fault = 1'b0;
        step();
        do_reset();

        // Back-to-back with rdy high: 3000, 3004, 3008
        for (int i = 0; i < 3; i++) do_instr(0, $urandom, 2'd0, 32'd0, 0);
        check_eq("seq_pc", pc, 32'h0000_300C);
        // Three wait states
        do_instr(3, $urandom, 2'd0, 32'd0, 0);
        check_eq("wait_pc", pc, 32'h0000_3010);
        // Backward branch from 3010
        do_instr(0, 32'h1000_FFFE, 2'd1, 32'd0, 0);
        check_eq("branch_pc", pc, 32'h0000_300C);
        // Jump
        do_instr(1, {6'h02, 26'h000_0C10}, 2'd2, 32'd0, 2);
        check_eq("jump_pc", pc, 32'h0000_3040);
        // JR to the top of memory, then wrap
        do_instr(0, $urandom, 2'd3, 32'hFFFF_FFFC, 2);
        do_instr(2, $urandom, 2'd0, 32'd0, 0);
        check_eq("wrap_pc", pc, 32'h0000_0000);
        // Misaligned JR halts
        do_instr(0, $urandom, 2'd3, 32'h0000_3021, 1);
        check_eq("jr_fault", 32'(fault), 32'd1);
        check_eq("jr_pc_kept", pc, 32'h0000_0000);
        do_reset();

        // Reset while FETCH waits; rdy shows up in the IDLE cycle after the reset edge
        imem_rdy = 1'b0;
        #1;
        check_eq("abort_req", 32'(imem_req), 32'd1);
        step();
        rst      = 1'b1;
        imem_rdy = 1'b0;
        #1;
        check_eq("abort_rst_req", 32'(imem_req), 32'd0);
        step();
        rst        = 1'b0;
        imem_rdy   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("abort_idle_req", 32'(imem_req), 32'd0);
        check_eq("abort_instr", instr, 32'd0);
        check_eq("abort_pc", pc, 32'h0000_3000);
        step();
        m_pc = 32'h0000_3000; m_instr = 32'd0; m_fault = 1'b0;
        do_instr(1, $urandom, 2'd0, 32'd0, 0);

        // Reset during EXEC drops the commit
        do_fetch(0, $urandom);
        do_reset();

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            logic [1:0]  op;
            logic [31:0] rs;
            op = 2'($urandom_range(0, 3));
            rs = $urandom & 32'hFFFF_FFFC;
            if (op == 2'd3 && $urandom_range(0, 9) == 0) rs = rs | 32'($urandom_range(1, 3));
            do_instr($urandom_range(0, 3), $urandom, op, rs, $urandom_range(0, 2));
            if (m_fault) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
